// File: rtl/mem_ctrl_if.sv
// Request/response channel between the CPU datapath and the load/store controller.
// master = CPU side, slave = mem_ctrl.
interface mem_ctrl_if #(
   parameter int AW = 12,
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [1:0]    req_size;
   logic          req_signed;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte/half/word load-store controller in front of a 1024x32 RAM with registered read.
// Optional MEM_CTRL_ALIGN_CHECK_EN: reject misaligned accesses and size 11 with rsp_err.
module mem_ctrl #(
   parameter int AW = 12,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_ctrl_if.slave     bus,
   output logic          mem_we_o,
   output logic [AW-3:0] mem_addr_o,
   output logic [DW-1:0] mem_din_o,
   input  logic [DW-1:0] mem_dout_i
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t        state_q, state_d;
   logic          we_q, signed_q;
   logic [1:0]    size_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, rdata_q, din_q;
   logic [DW-1:0] rdata_d, merged_d;
   logic [3:0]    lane_sel;
   logic [7:0]    byte_v;
   logic [15:0]   half_v;
   logic          accept, req_err;
   logic [1:0]    size_in;

   assign accept = (state_q == IDLE) && bus.req_valid;

`ifdef MEM_CTRL_ALIGN_CHECK_EN
   logic err_q;

   assign req_err = (bus.req_size == 2'b11) ||
                    ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                    ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
   assign size_in = bus.req_size;
   assign bus.rsp_err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (accept) begin
         err_q <= req_err;
      end
   end
`else
   // Without checking, size 11 behaves as a word and low address bits are masked by the lane logic.
   assign req_err = 1'b0;
   assign size_in = (bus.req_size == 2'b11) ? 2'b10 : bus.req_size;
   assign bus.rsp_err = 1'b0;
`endif

   // Byte lanes written by a store: the right-aligned store data is steered onto its lane.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         localparam logic [1:0] LANE = 2'(gi);
         localparam int         HB   = gi % 2;
         logic [7:0] store_byte;

         assign lane_sel[gi] = (size_q == 2'b00) ? (addr_q[1:0] == LANE) :
                               (size_q == 2'b01) ? (addr_q[1] == LANE[1]) : 1'b1;
         assign store_byte   = (size_q == 2'b00) ? wdata_q[7:0] :
                               (size_q == 2'b01) ? wdata_q[8*HB +: 8] : wdata_q[8*gi +: 8];
         assign merged_d[8*gi +: 8] = lane_sel[gi] ? store_byte : mem_dout_i[8*gi +: 8];
      end
   endgenerate

   assign byte_v = mem_dout_i[{addr_q[1:0], 3'b000} +: 8];
   assign half_v = addr_q[1] ? mem_dout_i[31:16] : mem_dout_i[15:0];

   always_comb begin
      case (size_q)
         2'b00:   rdata_d = {{(DW-8){signed_q & byte_v[7]}}, byte_v};
         2'b01:   rdata_d = {{(DW-16){signed_q & half_v[15]}}, half_v};
         default: rdata_d = mem_dout_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         signed_q <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         din_q    <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            we_q     <= bus.req_we;
            size_q   <= size_in;
            signed_q <= bus.req_signed;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= '0;
         end
         if (state_q == CAP) begin
            rdata_q <= rdata_d;
         end
         if (state_q == WR) begin
            din_q <= merged_d;
         end
      end
   end

   assign bus.rsp_rdata = rdata_q;
   assign mem_addr_o    = addr_q[AW-1:2];

   always_comb begin
      state_d       = state_q;
      bus.req_ready = 1'b0;
      bus.rsp_valid = 1'b0;
      mem_we_o      = 1'b0;
      mem_din_o     = din_q;
      case (state_q)
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (req_err) begin
                  state_d = RESP;
               end else if (!bus.req_we) begin
                  state_d = RD;
               end else if (size_in == 2'b10) begin
                  state_d = WR;
               end else begin
                  state_d = RD;
               end
            end
         end
         RD: begin
            state_d = we_q ? WR : CAP;
         end
         CAP: begin
            state_d = RESP;
         end
         WR: begin
            mem_we_o  = 1'b1;
            mem_din_o = merged_d;
            state_d   = RESP;
         end
         RESP: begin
            bus.rsp_valid = 1'b1;
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed vector table, backpressure and reset corner cases,
// then random traffic against a byte-array reference memory.
module tb_mem_ctrl;

   logic        clk;
   logic        rst_n;
   logic        mem_we;
   logic [9:0]  mem_addr;
   logic [31:0] mem_din;
   logic [31:0] mem_dout;
   logic [31:0] ram [1024];
   logic [7:0]  ref_mem [4096];

   int n_vec = 0;
   int n_err = 0;

   mem_ctrl_if #(.AW(12), .DW(32)) bus ();

   mem_ctrl #(.AW(12), .DW(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .mem_we_o   (mem_we),
      .mem_addr_o (mem_addr),
      .mem_din_o  (mem_din),
      .mem_dout_i (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM with registered read; output holds during a write cycle.
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr] <= mem_din;
      else        mem_dout <= ram[mem_addr];
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sgn;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
   } vec_t;

   vec_t tbl [15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: memory as a byte array, access computed from size/alignment arithmetic.
   task automatic model_access(input logic we, input logic [1:0] size, input logic sgn,
                               input logic [11:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err, output int lat);
      int nb;
      int base;
      logic [31:0] v;
      err   = 1'b0;
      rdata = 32'h0;
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      err = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
`endif
      if (err) begin
         lat = 1;
         return;
      end
      nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      base = int'(addr) - (int'(addr) % nb);
      if (we) begin
         for (int i = 0; i < nb; i++) ref_mem[base + i] = wdata[8*i +: 8];
         lat = (nb == 4) ? 2 : 3;
      end else begin
         v = 32'h0;
         for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[base + i]) << (8*i));
         if (sgn && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8*nb)) - 32'd1);
         rdata = v;
         lat   = 3;
      end
   endtask

   task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [11:0] addr, input logic [31:0] wdata, input int stall,
                         output logic [31:0] rdata, output logic err, output int lat,
                         output int wecnt, output int bad_addr);
      int n;
      rdata = 32'h0;
      err = 1'b0;
      lat = 0;
      wecnt = 0;
      bad_addr = 0;
      @(negedge clk);
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      bus.req_valid  = 1'b1;
      bus.rsp_ready  = (stall == 0);
      n = 0;
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
         bus.req_valid = 1'b0;
         bus.rsp_ready = 1'b1;
         return;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (mem_we) begin
            wecnt++;
            if (mem_addr != addr[11:2]) bad_addr++;
         end
      end while (!bus.rsp_valid && lat < 50);
      if (!bus.rsp_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within 50 cycles");
         bus.rsp_ready = 1'b1;
         return;
      end
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
      for (int k = 0; k < stall; k++) begin
         if (k == 0) begin
            bus.req_valid = 1'b1;
            bus.req_we    = 1'b1;
            bus.req_size  = 2'd2;
            bus.req_addr  = addr ^ 12'h004;
            bus.req_wdata = ~wdata;
         end
         @(negedge clk);
         check("stall_rsp_valid", 32'(bus.rsp_valid), 32'd1);
         check("stall_rsp_rdata", bus.rsp_rdata, rdata);
         check("stall_req_ready", 32'(bus.req_ready), 32'd0);
         if (mem_we) wecnt++;
      end
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic run_txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                          input logic [11:0] addr, input logic [31:0] wdata, input int stall,
                          input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      logic [31:0] rd;
      logic        er;
      int          lat, wecnt, bad;
      do_req(we, size, sgn, addr, wdata, stall, rd, er, lat, wecnt, bad);
      check({tag, "_rdata"}, rd, exp_rdata);
      check({tag, "_err"}, 32'(er), 32'(exp_err));
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_we_pulses"}, 32'(wecnt), (we && !exp_err) ? 32'd1 : 32'd0);
      check({tag, "_we_addr"}, 32'(bad), 32'd0);
      $display("txn %s we=%0b size=%0d sgn=%0b addr=%h wdata=%h stall=%0d -> rdata=%h err=%0b lat=%0d",
               tag, we, size, sgn, addr, wdata, stall, rd, er, lat);
   endtask

   initial begin
      logic [31:0] m_rdata;
      logic        m_err;
      int          m_lat;
      logic [31:0] ram3_init, ram5_init;
      logic        r_we, r_sgn;
      logic [1:0]  r_size;
      logic [11:0] r_addr;
      logic [31:0] r_wdata;
      int          r_stall;
      int          mism;

      for (int w = 0; w < 1024; w++) begin
         ram[w] = $urandom;
         for (int b = 0; b < 4; b++) ref_mem[4*w + b] = ram[w][8*b +: 8];
      end
      ram3_init = ram[3];
      ram5_init = ram[5];

      tbl[0]  = '{1'b1, 2'd2, 1'b0, 12'h010, 32'hDEADBEEF, 32'h00000000, 1'b0, 2};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h00000000, 32'hDEADBEEF, 1'b0, 3};
      tbl[2]  = '{1'b1, 2'd0, 1'b0, 12'h011, 32'hAAAAAA55, 32'h00000000, 1'b0, 3};
      tbl[3]  = '{1'b0, 2'd0, 1'b1, 12'h013, 32'h00000000, 32'hFFFFFFDE, 1'b0, 3};
      tbl[4]  = '{1'b0, 2'd1, 1'b0, 12'h012, 32'h00000000, 32'h0000DEAD, 1'b0, 3};
      tbl[5]  = '{1'b0, 2'd1, 1'b1, 12'h010, 32'h00000000, 32'h000055EF, 1'b0, 3};
      tbl[6]  = '{1'b1, 2'd1, 1'b0, 12'h022, 32'h12348001, 32'h00000000, 1'b0, 3};
      tbl[7]  = '{1'b0, 2'd1, 1'b1, 12'h022, 32'h00000000, 32'hFFFF8001, 1'b0, 3};
      tbl[8]  = '{1'b0, 2'd0, 1'b0, 12'h023, 32'h00000000, 32'h00000080, 1'b0, 3};
      tbl[9]  = '{1'b0, 2'd0, 1'b1, 12'h022, 32'h00000000, 32'h00000001, 1'b0, 3};
`ifdef MEM_CTRL_ALIGN_CHECK_EN
      tbl[10] = '{1'b0, 2'd2, 1'b0, 12'h012, 32'h00000000, 32'h00000000, 1'b1, 1};
      tbl[11] = '{1'b0, 2'd3, 1'b0, 12'h010, 32'h00000000, 32'h00000000, 1'b1, 1};
      tbl[12] = '{1'b0, 2'd1, 1'b1, 12'h011, 32'h00000000, 32'h00000000, 1'b1, 1};
`else
      tbl[10] = '{1'b0, 2'd2, 1'b0, 12'h012, 32'h00000000, 32'hDEAD55EF, 1'b0, 3};
      tbl[11] = '{1'b0, 2'd3, 1'b0, 12'h010, 32'h00000000, 32'hDEAD55EF, 1'b0, 3};
      tbl[12] = '{1'b0, 2'd1, 1'b1, 12'h011, 32'h00000000, 32'h000055EF, 1'b0, 3};
`endif
      tbl[13] = '{1'b1, 2'd0, 1'b0, 12'h013, 32'h123456FF, 32'h00000000, 1'b0, 3};
      tbl[14] = '{1'b0, 2'd2, 1'b0, 12'h010, 32'h00000000, 32'hFFAD55EF, 1'b0, 3};

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'd0;
      bus.req_signed = 1'b0;
      bus.req_addr   = 12'h0;
      bus.req_wdata  = 32'h0;
      bus.rsp_ready  = 1'b1;
      #23;
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err",   32'(bus.rsp_err), 32'd0);
      check("rst_mem_we",    32'(mem_we), 32'd0);
      check("rst_mem_addr",  32'(mem_addr), 32'd0);
      check("rst_mem_din",   mem_din, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 15; i++) begin
         model_access(tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, m_rdata, m_err, m_lat);
         run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].size, tbl[i].sgn, tbl[i].addr, tbl[i].wdata, 0,
                 tbl[i].exp_rdata, tbl[i].exp_err, tbl[i].exp_lat);
      end
      check("ram4_after_stores", ram[4], 32'hFFAD55EF);
      check("ram3_untouched", ram[3], ram3_init);
      check("ram5_untouched", ram[5], ram5_init);

      // Response held off for 5 cycles while another request is waved at the controller.
      run_txn("backpressure", 1'b0, 2'd2, 1'b0, 12'h010, 32'h0, 5, 32'hFFAD55EF, 1'b0, 3);
      check("ram0x14_not_written", ram[5], ram5_init);
      run_txn("after_backpressure", 1'b0, 2'd0, 1'b0, 12'h012, 32'h0, 0, 32'h000000AD, 1'b0, 3);

      // Reset asserted during the write cycle of a word store: the store is lost.
      @(negedge clk);
      bus.req_we    = 1'b1;
      bus.req_size  = 2'd2;
      bus.req_addr  = 12'h040;
      bus.req_wdata = 32'hCAFEF00D;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_mem_din", mem_din, 32'hCAFEF00D);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_rst_mem_we", 32'(mem_we), 32'd0);
      check("async_rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("async_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_access(1'b0, 2'd2, 1'b0, 12'h040, 32'h0, m_rdata, m_err, m_lat);
      run_txn("load_after_reset", 1'b0, 2'd2, 1'b0, 12'h040, 32'h0, 0, m_rdata, m_err, m_lat);

      for (int t = 0; t < 250; t++) begin
         r_we    = 1'($urandom_range(0, 1));
         r_size  = 2'($urandom_range(0, 3));
         r_sgn   = 1'($urandom_range(0, 1));
         r_addr  = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'($urandom_range(0, 127));
         r_wdata = $urandom;
         r_stall = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         model_access(r_we, r_size, r_sgn, r_addr, r_wdata, m_rdata, m_err, m_lat);
         run_txn($sformatf("rnd%0d", t), r_we, r_size, r_sgn, r_addr, r_wdata, r_stall, m_rdata, m_err, m_lat);
      end

      mism = 0;
      for (int w = 0; w < 1024; w++) begin
         if (ram[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) mism++;
      end
      check("ram_scan_mismatched_words", 32'(mism), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
